// File: rtl/frame_ram_pkg.sv
// Shared definitions for the frame RAM arbiter.
// Contents: default RAM geometry, capture frame size, grant-type encoding.
package frame_ram_pkg;

  localparam int ADDR_W_DEF         = 17;
  localparam int DATA_W_DEF         = 16;
  localparam int IMAGE_CAPTURE_SIZE = 240 * 240 * 2;

  // What the arbiter issues to the RAM in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port.
// Ports: clk, reset_n (sync, active low), push/wdata, pop, rdata (head),
//        full, empty, count (occupancy 0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    rptr_d = pop_ok  ? rptr_q + AW'(1) : rptr_q;
    wptr_d = push_ok ? wptr_q + AW'(1) : wptr_q;
    cnt_d  = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Arbitrates the shared frame RAM between posted pixel writes (FIFO
// buffered) and request/grant SPI readout reads with fixed-latency return.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data        pixel write stream (never stalls)
//   wr_full, wr_overflow         FIFO full, sticky drop flag
//   clear_ovf                    clears wr_overflow (and stats counters)
//   rd_req/rd_addr, rd_gnt       read request held until grant pulse
//   rd_valid/rd_data             read return, RD_LATENCY+1 cycles after grant
//   idle                         nothing queued, requested or in flight
//   ram_address/ram_data_in/ram_write_en/ram_data_out  registered RAM port
// Optional build macro FRAME_RAM_ARB_STATS_EN adds drop_count and
// rd_stall_count (16-bit saturating).
module frame_ram_arbiter
  import frame_ram_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int RD_LATENCY    = 2,
  parameter int WR_BURST_MAX  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic              wr_overflow,
  input  logic              clear_ovf,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              idle,
`ifdef FRAME_RAM_ARB_STATS_EN
  output logic [15:0]       drop_count,
  output logic [15:0]       rd_stall_count,
`endif
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_en,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int FW = ADDR_W + DATA_W;
  localparam int CW = $clog2(WR_FIFO_DEPTH);
  localparam int BW = $clog2(WR_BURST_MAX + 1);

  logic [FW-1:0] fifo_head;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW:0]   fifo_count;
  logic          drop;

  gnt_e          sel;
  logic          burst_hit;
  logic [BW-1:0] burst_q, burst_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              ovf_q, ovf_d;

  logic [RD_LATENCY:0] vld_pipe_q;
  logic [DATA_W-1:0]   rd_hold_q;

  sync_fifo #(
    .DEPTH (WR_FIFO_DEPTH),
    .WIDTH (FW)
  ) u_wr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   ({wr_addr, wr_data}),
    .pop     (fifo_pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign burst_hit = (burst_q == BW'(WR_BURST_MAX));

  // Writes win unless a read has waited through a full burst. Gated by
  // reset_n so nothing is granted or popped while reset is held.
  always_comb begin
    sel = GNT_NONE;
    if (reset_n) begin
      if (!fifo_empty && !(rd_req && burst_hit)) sel = GNT_WR;
      else if (rd_req)                           sel = GNT_RD;
    end
  end

  assign fifo_pop  = (sel == GNT_WR);
  assign rd_gnt    = (sel == GNT_RD);
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign drop      = wr_en && fifo_full && !fifo_pop;
  assign fifo_push = wr_en && !drop;

  always_comb begin
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    burst_d = burst_q;
    unique case (sel)
      GNT_WR: begin
        addr_d  = fifo_head[FW-1:DATA_W];
        din_d   = fifo_head[DATA_W-1:0];
        we_d    = 1'b1;
        burst_d = rd_req ? burst_q + BW'(1) : '0;
      end
      GNT_RD: begin
        addr_d  = rd_addr;
        burst_d = '0;
      end
      default: ;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      burst_q    <= '0;
      ovf_q      <= 1'b0;
      vld_pipe_q <= '0;
      rd_hold_q  <= '0;
    end else begin
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      burst_q    <= burst_d;
      ovf_q      <= ovf_d;
      // Bit 0 marks the cycle the read address is on the RAM port; the
      // top bit lines up with ram_data_out valid.
      vld_pipe_q <= {vld_pipe_q[RD_LATENCY-1:0], rd_gnt};
      if (rd_valid) rd_hold_q <= ram_data_out;
    end
  end

  assign ram_address  = addr_q;
  assign ram_data_in  = din_q;
  assign ram_write_en = we_q;
  assign wr_full      = (fifo_count == (CW+1)'(WR_FIFO_DEPTH));
  assign wr_overflow  = ovf_q;
  assign rd_valid     = vld_pipe_q[RD_LATENCY];
  // Pass RAM data straight through on the valid cycle, hold it otherwise.
  assign rd_data      = rd_valid ? ram_data_out : rd_hold_q;
  assign idle         = !reset_n || (fifo_empty && !rd_req && (vld_pipe_q == '0));

`ifdef FRAME_RAM_ARB_STATS_EN
  logic [15:0] drop_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear_ovf) begin
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (drop && (drop_cnt_q != 16'hFFFF))              drop_cnt_q  <= drop_cnt_q + 16'd1;
      if (rd_req && !rd_gnt && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign drop_count     = drop_cnt_q;
  assign rd_stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/frame_ram_arbiter.md
Name: frame_ram_arbiter

Overview:
- Shares the single 128 KB frame RAM (17-bit byte address, 16-bit words) between two requesters.
- Camera pixel writer: posted writes, buffered in a small FIFO, never stalls the capture path.
- SPI image readout: request/grant reads with fixed-latency return.
- Replaces ad-hoc read-wait counters in the top level with one arbitrated, pipelined access point in the clk_24mhz domain.

Parameters:
- ADDR_W, 17, RAM byte address width.
- DATA_W, 16, RAM word width.
- WR_FIFO_DEPTH, 4, write FIFO entries (power of two, >=2).
- RD_LATENCY, 2, cycles from RAM address presented to ram_data_out valid.
- WR_BURST_MAX, 8, consecutive write grants allowed while a read is pending before one read is forced.

Ports:
- clk  in  1  system clock (clk_24mhz in top).
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  pixel write strobe, one word per cycle max.
- wr_addr  in  ADDR_W  byte address of pixel word.
- wr_data  in  DATA_W  pixel word.
- wr_full  out  1  FIFO full; informational, writer does not stall.
- wr_overflow  out  1  sticky: a write was dropped.
- clear_ovf  in  1  clears wr_overflow.
- rd_req  in  1  read request; held with rd_addr until rd_gnt.
- rd_addr  in  ADDR_W  byte address to read.
- rd_gnt  out  1  one-cycle pulse: read issued this cycle.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  DATA_W  returned word.
- idle  out  1  FIFO empty, no read pending or in flight.
- ram_address  out  ADDR_W  to ram_if.
- ram_data_in  out  DATA_W  to ram_if.
- ram_write_en  out  1  to ram_if.
- ram_data_out  in  DATA_W  from ram_if.

Behaviour:
- Reset (reset_n=0 at posedge clk): FIFO emptied; read shift register cleared (in-flight reads discarded, no rd_valid); burst counter=0. All outputs 0 except idle=1.
- Issue cycle, one RAM access per cycle, decision from registered state:
  - W: FIFO non-empty and not (rd_req && burst_cnt==WR_BURST_MAX). Pop head to ram_address/ram_data_in, ram_write_en=1. burst_cnt++ if rd_req, else burst_cnt=0.
  - R: rd_req and (FIFO empty or burst_cnt==WR_BURST_MAX). ram_address=rd_addr, ram_write_en=0, rd_gnt=1, burst_cnt=0.
  - IDLE: ram_write_en=0, ram_address holds its last value.
- RAM outputs registered; the access reaches ram_if on the cycle after the decision.
- Reads pipelined: back-to-back grants allowed; rd_valid/rd_data emerge exactly RD_LATENCY+1 cycles after rd_gnt, in order. rd_data holds its value between pulses.
- FIFO:
  - wr_en with FIFO full and no pop this cycle: word dropped, wr_overflow set next cycle.
  - wr_en with FIFO full and a simultaneous pop: accepted, count unchanged.
  - wr_full = (count==WR_FIFO_DEPTH).
  - clear_ovf and a new drop in the same cycle: flag stays set.
- Write-after-read ordering between requesters is not enforced; the top level sequences capture vs readout.
- rd_req deasserted without a grant: request abandoned, no side effect.

Optional Feature:
- Macro: FRAME_RAM_ARB_STATS_EN.
- With it: adds outputs drop_count (16 bit, saturating, counts dropped writes) and rd_stall_count (16 bit, saturating, cycles with rd_req=1 and rd_gnt=0). Both cleared by reset and by clear_ovf.
- Without it: neither port nor the counter logic exists.

Decomposition:
- Shared package frame_ram_pkg: ADDR_W/DATA_W defaults, IMAGE_CAPTURE_SIZE (240*240*2), grant-type encoding (GNT_NONE, GNT_WR, GNT_RD).
- Sub-module sync_fifo: parameterised depth/width, push/pop/full/empty/count.
- Read-latency shift register stays inline.

Test Plan:
- Reset with rd_req=1, wr_en=1 held -> no RAM access, rd_gnt=0, idle=1 while reset_n=0. First write reaches ram_write_en 2 cycles after release.
- Single read: rd_req, rd_addr=0x00100, RAM model returns 0xBEEF -> rd_gnt pulse, rd_valid with rd_data=0xBEEF exactly 3 cycles later.
- 16 back-to-back reads at addr 0,2,...,30 with writes idle -> 16 consecutive grants; rd_data sequence matches in order; 32 bytes returned in 16 rd_valid pulses.
- Continuous wr_en for 20 cycles with rd_req held -> after 8 writes one read is granted; pattern 8W/1R repeats; no drops (wr_overflow=0).
- Stall FIFO drain with a forced-read phase and push 6 words into depth 4 -> exactly the excess words dropped, wr_overflow=1; clear_ovf -> 0. With stats macro, drop_count equals the number of dropped words.
- Reset asserted 1 cycle after rd_gnt -> no rd_valid ever emitted for that read.
